// File: rtl/g_stage_ctrl.sv
// g_stage_ctrl: sequences one polar-decoder g layer. Reads LLR pairs
// (base+k, base+k+P) for k = 0..P-1, queues the returned r1/r2 with the
// partial-sum bit b in a 2-entry FIFO, and streams the external g-unit
// result out with its pair index.
//
// Handshake: a result transfers on a cycle where out_valid_o and
// out_ready_i are both 1. While out_valid_o=1 the head (operands, data,
// index) stays put until that transfer happens. Memory reads are issued
// only when the FIFO is guaranteed room for the returning data, so no
// back-pressure is ever needed on the read-data side.
module g_stage_ctrl #(
   parameter int bitwidth  = 7,
   parameter int MAX_LOG_N = 5,
   parameter int AW        = 8
) (
   input  logic                                 clk_i,
   input  logic                                 rst_i,
   input  logic                                 start_i,
   input  logic [$clog2(MAX_LOG_N+1)-1:0]       log_len_i,
   input  logic [AW-1:0]                        base_i,
   input  logic [2**(MAX_LOG_N-1)-1:0]          psum_i,
   output logic                                 busy_o,
   output logic                                 done_o,
   output logic                                 err_o,
   output logic                                 rd_en_o,
   output logic [AW-1:0]                        rd_addr_a_o,
   output logic [AW-1:0]                        rd_addr_b_o,
   input  logic [bitwidth-1:0]                  rd_data_a_i,
   input  logic [bitwidth-1:0]                  rd_data_b_i,
   output logic [bitwidth-1:0]                  g_r1_o,
   output logic [bitwidth-1:0]                  g_r2_o,
   output logic                                 g_b_o,
   input  logic [bitwidth-1:0]                  g_res_i,
   output logic                                 out_valid_o,
   input  logic                                 out_ready_i,
   output logic [bitwidth-1:0]                  out_data_o,
   output logic [MAX_LOG_N-2:0]                 out_idx_o,
   output logic [1:0]                           dbg_state_o
);

   localparam int LW = $clog2(MAX_LOG_N+1);
   localparam int PW = 2**(MAX_LOG_N-1);
   localparam int KW = MAX_LOG_N-1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic              done_q, done_d;
   logic              err_q, err_d;

   logic [AW-1:0]     base_q;
   logic [LW-1:0]     len_q;
   logic [PW-1:0]     psum_q;
   logic [KW-1:0]     rd_k_q;
   logic              pend_q;
   logic [KW-1:0]     pend_k_q;

   logic [bitwidth-1:0] r1_q [2];
   logic [bitwidth-1:0] r2_q [2];
   logic                b_q  [2];
   logic [KW-1:0]       k_q  [2];
   logic                wr_ptr_q, rd_ptr_q;
   logic [1:0]          cnt_q;

   logic [MAX_LOG_N-1:0] pair_oh;
   logic [KW-1:0]        last_k;
   logic                 len_legal;
   logic                 start_acc;
   logic                 fifo_valid;
   logic                 pop;
   logic                 rd_room;
   logic                 rd_en;

   // P = 2^(n-1) as a one-hot value; last pair index is P-1 (wraps in KW bits for P = 2^KW)
   assign pair_oh    = MAX_LOG_N'(1) << (len_q - LW'(1));
   assign last_k     = KW'(pair_oh - MAX_LOG_N'(1));
   assign len_legal  = (log_len_i != '0) && (log_len_i <= LW'(MAX_LOG_N));
   assign start_acc  = (state_q == S_IDLE) && start_i && len_legal;
   assign fifo_valid = (cnt_q != 2'd0);
   assign pop        = fifo_valid && out_ready_i && !rst_i;
   // occupancy + in-flight - same-cycle pop must stay below 2 before another read
   assign rd_room    = ({1'b0, cnt_q} + {2'b00, pend_q}) < (3'd2 + {2'b00, pop});
   assign rd_en      = (state_q == S_RUN) && rd_room && !rst_i;

   // FSM state register plus the registered done/err pulses
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   // Next-state logic: RUN until the last read issues, DRAIN until the last pop
   always_comb begin
      state_d = state_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               if (len_legal) state_d = S_RUN;
               else           err_d   = 1'b1;
            end
         end
         S_RUN: begin
            if (rd_en && (rd_k_q == last_k)) state_d = S_DRAIN;
         end
         S_DRAIN: begin
            if (pop && (k_q[rd_ptr_q] == last_k)) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Layer parameters, read counter, in-flight tracking and the result FIFO
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         base_q   <= '0;
         len_q    <= '0;
         psum_q   <= '0;
         rd_k_q   <= '0;
         pend_q   <= 1'b0;
         pend_k_q <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         cnt_q    <= 2'd0;
         for (int i = 0; i < 2; i++) begin
            r1_q[i] <= '0;
            r2_q[i] <= '0;
            b_q[i]  <= 1'b0;
            k_q[i]  <= '0;
         end
      end else begin
         if (start_acc) begin
            base_q <= base_i;
            len_q  <= log_len_i;
            psum_q <= psum_i;
            rd_k_q <= '0;
         end else if (rd_en) begin
            rd_k_q <= rd_k_q + KW'(1);
         end
         pend_q <= rd_en;
         if (rd_en) pend_k_q <= rd_k_q;
         if (pend_q) begin
            r1_q[wr_ptr_q] <= rd_data_a_i;
            r2_q[wr_ptr_q] <= rd_data_b_i;
            b_q[wr_ptr_q]  <= psum_q[pend_k_q];
            k_q[wr_ptr_q]  <= pend_k_q;
            wr_ptr_q       <= ~wr_ptr_q;
         end
         if (pop) rd_ptr_q <= ~rd_ptr_q;
         cnt_q <= cnt_q + {1'b0, pend_q} - {1'b0, pop};
      end
   end

   // Outputs are forced to zero whenever nothing valid is being presented
   always_comb begin
      busy_o      = (state_q != S_IDLE) && !rst_i;
      done_o      = done_q && !rst_i;
      err_o       = err_q && !rst_i;
      rd_en_o     = rd_en;
      rd_addr_a_o = '0;
      rd_addr_b_o = '0;
      out_valid_o = fifo_valid && !rst_i;
      g_r1_o      = '0;
      g_r2_o      = '0;
      g_b_o       = 1'b0;
      out_data_o  = '0;
      out_idx_o   = '0;
      dbg_state_o = state_q;
      if (rd_en) begin
         rd_addr_a_o = base_q + AW'(rd_k_q);
         rd_addr_b_o = base_q + AW'(rd_k_q) + AW'(pair_oh);
      end
      if (fifo_valid && !rst_i) begin
         g_r1_o     = r1_q[rd_ptr_q];
         g_r2_o     = r2_q[rd_ptr_q];
         g_b_o      = b_q[rd_ptr_q];
         out_data_o = g_res_i;
         out_idx_o  = k_q[rd_ptr_q];
      end
   end

endmodule

// File: tb/tb_g_stage_ctrl.sv
// Directed bench for g_stage_ctrl: a table of layers run through one
// task, plus hand sequences for illegal starts, mid-layer reset and a
// back-to-back start in the done cycle.
module tb_g_stage_ctrl;

   localparam int W   = 7;
   localparam int MLN = 5;
   localparam int AW  = 8;
   localparam int LW  = 3;
   localparam int PW  = 16;
   localparam int KW  = 4;

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic          start_i;
   logic [LW-1:0] log_len_i;
   logic [AW-1:0] base_i;
   logic [PW-1:0] psum_i;
   logic          busy_o, done_o, err_o, rd_en_o;
   logic [AW-1:0] rd_addr_a_o, rd_addr_b_o;
   logic [W-1:0]  rd_data_a_i, rd_data_b_i;
   logic [W-1:0]  g_r1_o, g_r2_o;
   logic          g_b_o;
   logic [W-1:0]  g_res_i;
   logic          out_valid_o, out_ready_i;
   logic [W-1:0]  out_data_o;
   logic [KW-1:0] out_idx_o;
   logic [1:0]    dbg_state_o;

   g_stage_ctrl #(.bitwidth(W), .MAX_LOG_N(MLN), .AW(AW)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .log_len_i(log_len_i),
      .base_i(base_i), .psum_i(psum_i), .busy_o(busy_o), .done_o(done_o),
      .err_o(err_o), .rd_en_o(rd_en_o), .rd_addr_a_o(rd_addr_a_o),
      .rd_addr_b_o(rd_addr_b_o), .rd_data_a_i(rd_data_a_i), .rd_data_b_i(rd_data_b_i),
      .g_r1_o(g_r1_o), .g_r2_o(g_r2_o), .g_b_o(g_b_o), .g_res_i(g_res_i),
      .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
      .out_idx_o(out_idx_o), .dbg_state_o(dbg_state_o)
   );

   // clock
   always #5 clk_i = ~clk_i;

   // LLR memory: one-cycle read latency, junk on cycles without a read
   logic [W-1:0] mem [256];
   always @(posedge clk_i) begin
      if (rd_en_o) begin
         rd_data_a_i <= mem[rd_addr_a_o];
         rd_data_b_i <= mem[rd_addr_b_o];
      end else begin
         rd_data_a_i <= W'($urandom);
         rd_data_b_i <= W'($urandom);
      end
   end

   // saturating g: r2 + r1 when b=0, r2 - r1 when b=1
   function automatic logic [W-1:0] g_fn(input logic [W-1:0] r1, input logic [W-1:0] r2, input logic b);
      int s;
      s = b ? (int'($signed(r2)) - int'($signed(r1))) : (int'($signed(r2)) + int'($signed(r1)));
      if (s > 63)  s = 63;
      if (s < -64) s = -64;
      return W'(s);
   endfunction

   assign g_res_i = g_fn(g_r1_o, g_r2_o, g_b_o);

   int total = 0;
   int bad   = 0;
   logic [KW+W:0] exp_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, "_busy"}, busy_o, 0);
      chk({tag, "_done"}, done_o, 0);
      chk({tag, "_err"}, err_o, 0);
      chk({tag, "_rd_en"}, rd_en_o, 0);
      chk({tag, "_addr_a"}, rd_addr_a_o, 0);
      chk({tag, "_addr_b"}, rd_addr_b_o, 0);
      chk({tag, "_valid"}, out_valid_o, 0);
      chk({tag, "_r1"}, g_r1_o, 0);
      chk({tag, "_r2"}, g_r2_o, 0);
      chk({tag, "_b"}, g_b_o, 0);
      chk({tag, "_data"}, out_data_o, 0);
      chk({tag, "_idx"}, out_idx_o, 0);
   endtask

   // Runs one layer. prestarted: start was already given in the previous
   // layer's done cycle. chain: give the next layer's start in this layer's
   // expected done cycle.
   task automatic run_layer(input int len, input int base, input logic [PW-1:0] ps, input bit stall,
                            input int exp_done, input bit prestarted, input bit chain,
                            input int c_len, input int c_base, input logic [PW-1:0] c_ps);
      int p, reads, pops, done_c, a, bb;
      bit hold_v;
      logic [KW-1:0] hold_idx;
      logic [W-1:0]  hold_data;
      logic [KW+W:0] e;
      p = 1 << (len - 1);
      exp_q.delete();
      for (int k = 0; k < p; k++) begin
         a  = (base + k) & 255;
         bb = (base + k + p) & 255;
         exp_q.push_back({KW'(k), ps[k], g_fn(mem[a], mem[bb], ps[k])});
      end
      reads = 0; pops = 0; done_c = -1; hold_v = 0;
      hold_idx = '0; hold_data = '0;
      for (int c = (prestarted ? 1 : 0); c < 200 && done_c < 0; c++) begin
         @(posedge clk_i); #1;
         start_i = (c == 0) || (chain && c == exp_done);
         if (c == 0) begin
            log_len_i = LW'(len); base_i = AW'(base); psum_i = ps;
         end else if (chain && c == exp_done) begin
            log_len_i = LW'(c_len); base_i = AW'(c_base); psum_i = c_ps;
         end else begin
            log_len_i = LW'($urandom_range(1, 5)); base_i = AW'($urandom); psum_i = PW'($urandom);
         end
         out_ready_i = !(stall && c >= 3 && c <= 6);
         @(negedge clk_i);
         if (hold_v) begin
            chk("hold_valid", out_valid_o, 1);
            chk("hold_idx", out_idx_o, hold_idx);
            chk("hold_data", out_data_o, hold_data);
         end
         hold_v = out_valid_o && !out_ready_i;
         hold_idx = out_idx_o;
         hold_data = out_data_o;
         chk("busy", busy_o, (c >= 1 && c < exp_done));
         if (!stall) begin
            chk("rd_en_slot", rd_en_o, (c >= 1 && c <= p));
            chk("valid_slot", out_valid_o, (c >= 3 && c <= p + 2));
         end
         if (rd_en_o) begin
            chk("rd_addr_a", rd_addr_a_o, (base + reads) & 255);
            chk("rd_addr_b", rd_addr_b_o, (base + reads + p) & 255);
            reads++;
         end
         if (out_valid_o && out_ready_i) begin
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               chk("out_idx", out_idx_o, e[KW+W:W+1]);
               chk("g_b", g_b_o, e[W]);
               chk("out_data", out_data_o, e[W-1:0]);
            end
            pops++;
         end
         if (stall) chk("outstanding_le2", (reads - pops) <= 2, 1);
         if (done_o) done_c = c;
      end
      chk("done_cycle", done_c, exp_done);
      chk("read_count", reads, p);
      chk("pop_count", pops, p);
   endtask

   typedef struct {
      int            len;
      int            base;
      logic [PW-1:0] psum;
      bit            stall;
      int            exp_done;
   } vec_t;

   vec_t vecs[6];

   initial begin
      // P+3 with ready high; P+7 with ready low in cycles 3..6
      vecs[0] = '{len: 3, base: 'h10, psum: 16'h0005, stall: 0, exp_done: 7};
      vecs[1] = '{len: 3, base: 'h10, psum: 16'h0005, stall: 1, exp_done: 11};
      vecs[2] = '{len: 2, base: 'hFE, psum: 16'h0002, stall: 0, exp_done: 5};
      vecs[3] = '{len: 1, base: 'h00, psum: 16'h0001, stall: 0, exp_done: 4};
      vecs[4] = '{len: 5, base: 'h40, psum: 16'hA5C3, stall: 0, exp_done: 19};
      vecs[5] = '{len: 4, base: 'hF8, psum: 16'h1234, stall: 1, exp_done: 15};

      for (int i = 0; i < 256; i++) mem[i] = W'(i * 37 + 11);

      // reset
      rst_i = 1'b1; start_i = 1'b0; log_len_i = '0; base_i = '0; psum_i = '0; out_ready_i = 1'b1;
      repeat (3) @(posedge clk_i);
      #1 rst_i = 1'b0;
      @(negedge clk_i);
      chk_quiet("reset");

      // table-driven layers
      for (int i = 0; i < 6; i++)
         run_layer(vecs[i].len, vecs[i].base, vecs[i].psum, vecs[i].stall, vecs[i].exp_done,
                   1'b0, 1'b0, 0, 0, '0);

      // start in the done cycle of the previous layer
      run_layer(3, 'h20, 16'h000F, 1'b0, 7, 1'b0, 1'b1, 2, 'h80, 16'h0003);
      run_layer(2, 'h80, 16'h0003, 1'b0, 5, 1'b1, 1'b0, 0, 0, '0);

      // illegal lengths
      for (int j = 0; j < 2; j++) begin
         @(posedge clk_i); #1;
         start_i = 1'b1; log_len_i = (j == 0) ? LW'(0) : LW'(MLN + 1);
         @(negedge clk_i);
         chk("illegal_err_c0", err_o, 0);
         @(posedge clk_i); #1;
         start_i = 1'b0;
         @(negedge clk_i);
         chk("illegal_err_c1", err_o, 1);
         chk("illegal_busy_c1", busy_o, 0);
         chk("illegal_rd_c1", rd_en_o, 0);
         @(posedge clk_i); #1;
         @(negedge clk_i);
         chk("illegal_err_c2", err_o, 0);
         chk("illegal_busy_c2", busy_o, 0);
         chk("illegal_rd_c2", rd_en_o, 0);
      end

      // reset in the middle of a layer
      @(posedge clk_i); #1;
      start_i = 1'b1; log_len_i = LW'(4); base_i = AW'('h30); psum_i = 16'h00FF; out_ready_i = 1'b1;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      chk("midrst_valid_before", out_valid_o, 1);
      @(posedge clk_i); #1;
      rst_i = 1'b1;
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      @(negedge clk_i);
      chk_quiet("midrst");
      for (int j = 0; j < 3; j++) begin
         @(posedge clk_i); #1;
         @(negedge clk_i);
         chk("midrst_stale_valid", out_valid_o, 0);
         chk("midrst_stale_rd", rd_en_o, 0);
      end
      run_layer(3, 'h10, 16'h0005, 1'b0, 7, 1'b0, 1'b0, 0, 0, '0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/g_stage_ctrl.md
G_STAGE_CTRL -- requirements
Module: g_stage_ctrl

Interface
REQ-001 SHALL have parameter bitwidth, default 7, LLR width in two's complement.
REQ-002 SHALL have parameter MAX_LOG_N, default 5, log2 of the largest supported code length.
REQ-003 SHALL have parameter AW, default 8, LLR memory address width.
REQ-004 SHALL have port clk_i  in  1  single clock, all logic on rising edge.
REQ-005 SHALL have port rst_i  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port start_i  in  1  request to process one g layer.
REQ-007 SHALL have port log_len_i  in  $clog2(MAX_LOG_N+1)  layer length n; pair count P=2^(n-1).
REQ-008 SHALL have port base_i  in  AW  LLR memory base address of the layer.
REQ-009 SHALL have port psum_i  in  2^(MAX_LOG_N-1)  partial-sum bits; bit k is b for pair k.
REQ-010 SHALL have port busy_o  out  1  layer in progress.
REQ-011 SHALL have port done_o  out  1  one-cycle pulse at layer completion.
REQ-012 SHALL have port err_o  out  1  one-cycle pulse on an illegal start.
REQ-013 SHALL have port rd_en_o  out  1  LLR memory read strobe.
REQ-014 SHALL have ports rd_addr_a_o and rd_addr_b_o  out  AW  addresses base+k and base+k+P.
REQ-015 SHALL have ports rd_data_a_i and rd_data_b_i  in  bitwidth  r1 and r2, valid exactly 1 cycle after rd_en_o.
REQ-016 SHALL have ports g_r1_o, g_r2_o  out  bitwidth, and g_b_o  out  1  operands to the external saturating g unit.
REQ-017 SHALL have port g_res_i  in  bitwidth  combinational g-unit result.
REQ-018 SHALL have ports out_valid_o  out  1, out_ready_i  in  1, out_data_o  out  bitwidth, out_idx_o  out  MAX_LOG_N-1  result stream.

Function
REQ-019 SHALL implement states IDLE, RUN, DRAIN; busy_o=1 in RUN and DRAIN.
REQ-020 SHALL accept start_i only in IDLE and SHALL ignore it in RUN/DRAIN.
REQ-021 SHALL treat start with log_len_i=0 or >MAX_LOG_N as illegal: err_o pulses next cycle, state stays IDLE.
REQ-022 SHALL latch base_i, log_len_i and psum_i on an accepted start; later input changes have no effect.
REQ-023 SHALL issue reads for k=0..P-1 in ascending order, one per cycle maximum, starting the cycle after start acceptance.
REQ-024 SHALL hold a 2-entry FIFO of {r1, r2, b, k}, written the cycle read data returns.
REQ-025 SHALL assert rd_en_o only when FIFO occupancy + reads in flight - (same-cycle pop) < 2, so the FIFO never overflows.
REQ-026 SHALL drive g_r1_o, g_r2_o, g_b_o from the FIFO head and out_data_o = g_res_i, out_idx_o = head k.
REQ-027 SHALL assert out_valid_o whenever the FIFO is non-empty; a pop occurs only when out_valid_o and out_ready_i are both 1.
REQ-028 SHALL hold out_data_o and out_idx_o stable while out_valid_o=1 and out_ready_i=0.
REQ-029 SHALL move RUN->DRAIN after issuing read k=P-1, and DRAIN->IDLE on the cycle after the pop of index P-1.
REQ-030 SHALL pulse done_o in that cycle and SHALL accept a new start in it.
REQ-031 SHALL sustain one result per cycle with out_ready_i held high: start at cycle 0, rd_en_o in cycles 1..P, out_valid_o in cycles 3..P+2, done_o in cycle P+3.
REQ-032 SHALL compute addresses modulo 2^AW, wrapping silently.

Reset
REQ-033 SHALL on rst_i force state IDLE, flush the FIFO and in-flight count, and drive busy_o, done_o, err_o, rd_en_o and out_valid_o to 0.
REQ-034 SHALL on rst_i drive rd_addr_a_o, rd_addr_b_o, g_r1_o, g_r2_o, g_b_o, out_data_o and out_idx_o to 0.
REQ-035 SHALL give rst_i priority over start_i, discarding any in-flight read data returning after reset.

Verification
REQ-036 SHALL verify n=3, base=0x10, psum=4'b0101, ready=1 -> reads (0x10,0x14)..(0x13,0x17); out_idx 0..3 in cycles 3..6; g_b_o = 1,0,1,0; done_o in cycle 7.
REQ-037 SHALL verify out_ready_i low for cycles 3-6 -> at most 2 reads outstanding, rd_en_o stalls, no data lost or reordered.
REQ-038 SHALL verify start with log_len_i=0 and with MAX_LOG_N+1 -> err_o single pulse, busy_o stays 0, no reads.
REQ-039 SHALL verify rst_i asserted in RUN mid-layer -> outputs zero next cycle, no out_valid_o from stale read, next start runs cleanly.
REQ-040 SHALL verify base=0xFE, n=2 -> rd_addr_b_o wraps to 0x00 and 0x01.
REQ-041 SHALL verify start_i asserted in the done_o cycle -> new layer accepted, first rd_en_o the following cycle.
